// File: rtl/piso_serializer_pkg.sv
// Shared FSM encodings and sizing helpers for the serializer family.
package piso_serializer_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_SHIFT  = 2'd1;
  localparam logic [STATE_W-1:0] ST_PARITY = 2'd2;

  // Bit counter width; a 2-bit word still needs one counter bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// WIDTH-bit parallel-load shift register; LSB_FIRST selects shift direction and tap.
module serial_shift_reg #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sbit
);

  logic [WIDTH-1:0] sr;

  generate
    if (LSB_FIRST != 0) begin : g_lsb
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        sr <= '0;
        else if (load)  sr <= din;
        else if (shift) sr <= {1'b0, sr[WIDTH-1:1]};
      end
      assign sbit = sr[0];
    end else begin : g_msb
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        sr <= '0;
        else if (load)  sr <= din;
        else if (shift) sr <= {sr[WIDTH-2:0], 1'b0};
      end
      assign sbit = sr[WIDTH-1];
    end
  endgenerate

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready input and framing strobes.
// Define SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [STATE_W-1:0] state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic               accept;
  logic               sbit;
  logic               last_data;

  assign accept    = din_valid && din_ready;
  assign last_data = (state == ST_SHIFT) && (cnt == CNT_LAST);

  serial_shift_reg #(
    .WIDTH    (WIDTH),
    .LSB_FIRST(LSB_FIRST)
  ) u_sr (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .shift((state == ST_SHIFT) && !accept),
    .din  (din),
    .sbit (sbit)
  );

`ifdef SERIALIZER_PARITY_EN
  logic par;

  // Running XOR of transmitted data bits; equals ^word once the parity cycle arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    par <= 1'b0;
    else if (accept)            par <= 1'b0;
    else if (state == ST_SHIFT) par <= par ^ sbit;
  end

  assign sout_last = (state == ST_PARITY);
  assign sout      = (state == ST_SHIFT) ? sbit : ((state == ST_PARITY) ? par : 1'b0);
`else
  assign sout_last = last_data;
  assign sout      = (state == ST_SHIFT) ? sbit : 1'b0;
`endif

  assign sout_valid = (state != ST_IDLE);
  assign busy       = sout_valid;
  assign sout_first = (state == ST_SHIFT) && (cnt == '0);
  // Held low during reset so no word can be accepted while the frame logic is cleared.
  assign din_ready  = !rst && ((state == ST_IDLE) || sout_last);

  always_comb begin
    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_SHIFT;
          cnt_nxt   = '0;
        end
      end
      ST_SHIFT: begin
        if (last_data) begin
          cnt_nxt = '0;
`ifdef SERIALIZER_PARITY_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = accept ? ST_SHIFT : ST_IDLE;
`endif
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`ifdef SERIALIZER_PARITY_EN
      ST_PARITY: begin
        cnt_nxt   = '0;
        state_nxt = accept ? ST_SHIFT : ST_IDLE;
      end
`endif
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: MSB-first and LSB-first instances share inputs; each scenario has its own task.
module tb_piso_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;

  logic m_ready, m_sout, m_valid, m_first, m_last, m_busy;
  logic l_ready, l_sout, l_valid, l_first, l_last, l_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(m_ready),
    .sout(m_sout), .sout_valid(m_valid), .sout_first(m_first), .sout_last(m_last), .busy(m_busy)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1)) dut_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(l_ready),
    .sout(l_sout), .sout_valid(l_valid), .sout_first(l_first), .sout_last(l_last), .busy(l_busy)
  );

  // Present a word at a falling edge, confirm it is accepted at the next rising edge.
  task automatic offer(input logic [7:0] word, input logic keep_valid);
    @(negedge clk);
    din       = word;
    din_valid = 1'b1;
    checks++;
    if (m_ready !== 1'b1) begin
      errors++;
      $display("FAIL offer_ready word=%h got=%b exp=1", word, m_ready);
    end
    @(posedge clk);
    #1;
    if (!keep_valid) din_valid = 1'b0;
  endtask

  // Checks one whole frame cycle by cycle; seq[7] is the first expected bit.
  // scramble drives changing din with din_valid=1 while din_ready should be low.
  task automatic check_frame(input string name, input logic sel, input logic [7:0] seq,
                             input logic par_bit, input logic scramble);
    logic s, v, f, l, b, r, exp_s;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      s = sel ? l_sout  : m_sout;
      v = sel ? l_valid : m_valid;
      f = sel ? l_first : m_first;
      l = sel ? l_last  : m_last;
      b = sel ? l_busy  : m_busy;
      r = sel ? l_ready : m_ready;
      exp_s = (i < 8) ? seq[7-i] : par_bit;
      checks++;
      if (s !== exp_s || v !== 1'b1 || b !== 1'b1 || f !== (i == 0) ||
          l !== (i == FRAME-1) || r !== (i == FRAME-1)) begin
        errors++;
        $display("FAIL %s bit%0d got sout=%b valid=%b busy=%b first=%b last=%b ready=%b exp sout=%b valid=1 busy=1 first=%b last=%b ready=%b",
                 name, i, s, v, b, f, l, r, exp_s, (i == 0), (i == FRAME-1), (i == FRAME-1));
      end
      if (scramble) begin
        din       = 8'h11 * i[7:0] + 8'h3B;
        din_valid = (i < FRAME-2);
      end
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || m_busy !== 1'b0 || m_sout !== 1'b0 || m_ready !== 1'b1 ||
        l_valid !== 1'b0 || l_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle got valid=%b busy=%b sout=%b ready=%b lvalid=%b lready=%b exp 0 0 0 1 0 1",
               name, m_valid, m_busy, m_sout, m_ready, l_valid, l_ready);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (m_ready !== 1'b0 || m_valid !== 1'b0 || m_sout !== 1'b0 || m_first !== 1'b0 ||
        m_last !== 1'b0 || m_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got ready=%b valid=%b sout=%b first=%b last=%b busy=%b exp all 0",
               m_ready, m_valid, m_sout, m_first, m_last, m_busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle("reset_release");
  endtask

  task automatic test_msb_first();
    offer(8'hA5, 1'b0);
    din = 8'h00;
    check_frame("msb_a5", 1'b0, 8'b1010_0101, 1'b0, 1'b0);
    check_idle("msb_a5_end");
  endtask

  task automatic test_lsb_first();
    offer(8'h01, 1'b0);
    check_frame("lsb_01", 1'b1, 8'b1000_0000, 1'b1, 1'b0);
    check_idle("lsb_01_end");
    offer(8'hC8, 1'b0);
    check_frame("lsb_c8", 1'b1, 8'b0001_0011, 1'b1, 1'b0);
    check_idle("lsb_c8_end");
  endtask

  task automatic test_back_to_back();
    offer(8'hFF, 1'b1);
    din = 8'h00;
    check_frame("b2b_ff", 1'b0, 8'b1111_1111, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    check_frame("b2b_00", 1'b0, 8'b0000_0000, 1'b0, 1'b0);
    check_idle("b2b_end");
  endtask

  task automatic test_reset_mid_frame();
    logic [2:0] got;
    offer(8'hC3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got[2-i] = m_sout;
    end
    checks++;
    if (got !== 3'b110) begin
      errors++;
      $display("FAIL mid_rst_prefix got=%b exp=110", got);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_busy !== 1'b0 || m_sout !== 1'b0 || m_first !== 1'b0 ||
        m_last !== 1'b0 || m_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_async got valid=%b busy=%b sout=%b first=%b last=%b ready=%b exp all 0",
               m_valid, m_busy, m_sout, m_first, m_last, m_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (m_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_release got ready=%b valid=%b exp ready=1 valid=0", m_ready, m_valid);
    end
    offer(8'h3C, 1'b0);
    check_frame("post_rst_3c", 1'b0, 8'b0011_1100, 1'b0, 1'b0);
    check_idle("post_rst_end");
  endtask

  task automatic test_parity();
    offer(8'h07, 1'b0);
    check_frame("par_07", 1'b0, 8'b0000_0111, 1'b1, 1'b0);
    check_idle("par_07_end");
    offer(8'h03, 1'b0);
    check_frame("par_03", 1'b0, 8'b0000_0011, 1'b0, 1'b0);
    check_idle("par_03_end");
  endtask

  task automatic test_ignore_busy_input();
    offer(8'h96, 1'b0);
    check_frame("ignore_96", 1'b0, 8'b1001_0110, 1'b0, 1'b1);
    din_valid = 1'b0;
    check_idle("ignore_end");
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_reset_mid_frame();
    test_parity();
    test_ignore_busy_input();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
